// File: rtl/uart_param_if.sv
// Host-side bundle for uart_param: TX valid/ready, RX valid/ack and RX status flags.
// The serial pins and clk/reset_n stay as plain ports on the UART itself.
interface uart_param_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  // Host / FIFO side
  modport master (
    output tx_data, tx_valid, rx_ack,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  // UART side
  modport slave (
    input  tx_data, tx_valid, rx_ack,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

endinterface

// File: rtl/uart_param.sv
// Parametrised full-duplex UART.
// TX: bit timer in raw clocks, restarted when a byte is accepted, so every bit is
//     exactly OVS*CLK_DIV clocks regardless of the free-running oversample tick.
// RX: 2-flop synchroniser, oversample tick, mid-bit sampling, false-start rejection,
//     parity/framing/overrun flags held until the host acknowledges.
module uart_param #(
  parameter int CLK_DIV   = 27,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx,
  output logic          tx,
  uart_param_if.slave   bus
);

  localparam int BIT_CLKS = OVS * CLK_DIV;
  localparam int TW       = $clog2(BIT_CLKS);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OW       = $clog2(OVS);
  localparam int BCW      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HI
  } rx_state_t;

  // ------------------------------------------------------------------
  // Oversample tick generator
  // ------------------------------------------------------------------
  logic [DW-1:0] r_div_cnt;
  logic          w_tick;

  assign w_tick = (r_div_cnt == DW'(CLK_DIV - 1));

  // Free-running divider, one-cycle tick on wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  tx_state_t            r_tx_state,  w_tx_state_next;
  logic [TW-1:0]        r_tx_timer,  w_tx_timer_next;
  logic [BCW-1:0]       r_tx_bitcnt, w_tx_bitcnt_next;
  logic [DATA_BITS-1:0] r_tx_shift,  w_tx_shift_next;
  logic                 r_tx_par,    w_tx_par_next;
  logic                 r_tx_line,   w_tx_line_next;
  logic                 w_tx_bit_done;

  assign w_tx_bit_done = (r_tx_timer == TW'(BIT_CLKS - 1));
  assign tx            = r_tx_line;
  assign bus.tx_ready  = (r_tx_state == TX_IDLE);

  // TX state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state  <= TX_IDLE;
      r_tx_timer  <= '0;
      r_tx_bitcnt <= '0;
      r_tx_shift  <= '0;
      r_tx_par    <= 1'b0;
      r_tx_line   <= 1'b1;
    end else begin
      r_tx_state  <= w_tx_state_next;
      r_tx_timer  <= w_tx_timer_next;
      r_tx_bitcnt <= w_tx_bitcnt_next;
      r_tx_shift  <= w_tx_shift_next;
      r_tx_par    <= w_tx_par_next;
      r_tx_line   <= w_tx_line_next;
    end
  end

  // TX next state: the line value is registered, so it changes on the same edge as the state
  always_comb begin
    w_tx_state_next  = r_tx_state;
    w_tx_timer_next  = r_tx_timer;
    w_tx_bitcnt_next = r_tx_bitcnt;
    w_tx_shift_next  = r_tx_shift;
    w_tx_par_next    = r_tx_par;
    w_tx_line_next   = r_tx_line;

    if (r_tx_state != TX_IDLE) begin
      w_tx_timer_next = w_tx_bit_done ? '0 : r_tx_timer + TW'(1);
    end

    case (r_tx_state)
      TX_IDLE: begin
        w_tx_line_next = 1'b1;
        if (bus.tx_valid) begin
          w_tx_shift_next = bus.tx_data;
          w_tx_par_next   = (PARITY == 1) ? ~(^bus.tx_data) : ^bus.tx_data;
          w_tx_timer_next = '0;
          w_tx_line_next  = 1'b0;
          w_tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (w_tx_bit_done) begin
          w_tx_state_next  = TX_DATA;
          w_tx_bitcnt_next = '0;
          w_tx_line_next   = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (w_tx_bit_done) begin
          if (r_tx_bitcnt == BCW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              w_tx_state_next = TX_PARITY;
              w_tx_line_next  = r_tx_par;
            end else begin
              w_tx_state_next  = TX_STOP;
              w_tx_line_next   = 1'b1;
              w_tx_bitcnt_next = '0;
            end
          end else begin
            w_tx_bitcnt_next = r_tx_bitcnt + BCW'(1);
            w_tx_shift_next  = {1'b0, r_tx_shift[DATA_BITS-1:1]};
            w_tx_line_next   = r_tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (w_tx_bit_done) begin
          w_tx_state_next  = TX_STOP;
          w_tx_line_next   = 1'b1;
          w_tx_bitcnt_next = '0;
        end
      end
      TX_STOP: begin
        if (w_tx_bit_done) begin
          if (r_tx_bitcnt == BCW'(STOP_BITS - 1)) begin
            w_tx_state_next = TX_IDLE;
          end else begin
            w_tx_bitcnt_next = r_tx_bitcnt + BCW'(1);
          end
        end
      end
      default: begin
        w_tx_state_next = TX_IDLE;
        w_tx_line_next  = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  logic [1:0] r_rx_sync;
  logic       w_rx_s;

  assign w_rx_s = r_rx_sync[1];

  // Two-flop synchroniser for the asynchronous serial input; idles high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_sync <= 2'b11;
    end else begin
      r_rx_sync <= {r_rx_sync[0], rx};
    end
  end

  rx_state_t            r_rx_state,  w_rx_state_next;
  logic [OW-1:0]        r_rx_tcnt,   w_rx_tcnt_next;
  logic [BCW-1:0]       r_rx_bitcnt, w_rx_bitcnt_next;
  logic [DATA_BITS-1:0] r_rx_shift,  w_rx_shift_next;
  logic                 r_rx_par,    w_rx_par_next;
  logic                 w_rx_done;
  logic                 w_rx_par_err;

  // RX state and shift registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state  <= RX_IDLE;
      r_rx_tcnt   <= '0;
      r_rx_bitcnt <= '0;
      r_rx_shift  <= '0;
      r_rx_par    <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_state_next;
      r_rx_tcnt   <= w_rx_tcnt_next;
      r_rx_bitcnt <= w_rx_bitcnt_next;
      r_rx_shift  <= w_rx_shift_next;
      r_rx_par    <= w_rx_par_next;
    end
  end

  // RX next state: start confirmed at half a bit, then one sample per OVS ticks
  always_comb begin
    w_rx_state_next  = r_rx_state;
    w_rx_tcnt_next   = r_rx_tcnt;
    w_rx_bitcnt_next = r_rx_bitcnt;
    w_rx_shift_next  = r_rx_shift;
    w_rx_par_next    = r_rx_par;
    w_rx_done        = 1'b0;

    case (r_rx_state)
      RX_IDLE: begin
        if (w_tick && !w_rx_s) begin
          w_rx_state_next = RX_START;
          w_rx_tcnt_next  = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_tcnt == OW'(OVS / 2 - 1)) begin
            w_rx_tcnt_next = '0;
            if (w_rx_s) begin
              // line went back high before mid start bit: a glitch, not a frame
              w_rx_state_next = RX_IDLE;
            end else begin
              w_rx_state_next  = RX_DATA;
              w_rx_bitcnt_next = '0;
            end
          end else begin
            w_rx_tcnt_next = r_rx_tcnt + OW'(1);
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rx_tcnt == OW'(OVS - 1)) begin
            w_rx_tcnt_next  = '0;
            w_rx_shift_next = {w_rx_s, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bitcnt == BCW'(DATA_BITS - 1)) begin
              w_rx_state_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              w_rx_bitcnt_next = r_rx_bitcnt + BCW'(1);
            end
          end else begin
            w_rx_tcnt_next = r_rx_tcnt + OW'(1);
          end
        end
      end
      RX_PARITY: begin
        if (w_tick) begin
          if (r_rx_tcnt == OW'(OVS - 1)) begin
            w_rx_tcnt_next  = '0;
            w_rx_par_next   = w_rx_s;
            w_rx_state_next = RX_STOP;
          end else begin
            w_rx_tcnt_next = r_rx_tcnt + OW'(1);
          end
        end
      end
      RX_STOP: begin
        if (w_tick) begin
          if (r_rx_tcnt == OW'(OVS - 1)) begin
            w_rx_tcnt_next  = '0;
            w_rx_done       = 1'b1;
            // a low stop bit (e.g. a break) must see the line high again before re-arming
            w_rx_state_next = w_rx_s ? RX_IDLE : RX_WAIT_HI;
          end else begin
            w_rx_tcnt_next = r_rx_tcnt + OW'(1);
          end
        end
      end
      RX_WAIT_HI: begin
        if (w_rx_s) begin
          w_rx_state_next = RX_IDLE;
        end
      end
      default: begin
        w_rx_state_next = RX_IDLE;
      end
    endcase
  end

  assign w_rx_par_err = (PARITY == 0) ? 1'b0 :
                        (PARITY == 1) ? (r_rx_par != ~(^r_rx_shift)) :
                                        (r_rx_par != (^r_rx_shift));

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rx_par_err;
  logic                 r_rx_frame_err;
  logic                 r_rx_overrun;

  // Host-facing RX result: a new frame always wins, ack clears everything otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rx_par_err   <= 1'b0;
      r_rx_frame_err <= 1'b0;
      r_rx_overrun   <= 1'b0;
    end else if (w_rx_done) begin
      r_rx_data      <= r_rx_shift;
      r_rx_valid     <= 1'b1;
      r_rx_par_err   <= w_rx_par_err;
      r_rx_frame_err <= ~w_rx_s;
      // unread data being replaced; a coincident ack means it was read in time
      r_rx_overrun   <= r_rx_valid & ~bus.rx_ack;
    end else if (bus.rx_ack && r_rx_valid) begin
      r_rx_valid     <= 1'b0;
      r_rx_par_err   <= 1'b0;
      r_rx_frame_err <= 1'b0;
      r_rx_overrun   <= 1'b0;
    end
  end

  assign bus.rx_data       = r_rx_data;
  assign bus.rx_valid      = r_rx_valid;
  assign bus.rx_parity_err = r_rx_par_err;
  assign bus.rx_frame_err  = r_rx_frame_err;
  assign bus.rx_overrun    = r_rx_overrun;

endmodule
